// File: rtl/fetch_byte_queue.sv
// fetch_byte_queue: instruction-fetch front end. Issues line-sized read bursts
// on a req/resp handshake, packs returned beats into a circular byte queue and
// presents a decode window at the current decode PC. A redirect flushes the
// queue and restarts fetch, discarding whatever is left of an in-flight burst.
module fetch_byte_queue #(
    parameter int BEAT_BYTES   = 8,
    parameter int LINE_BYTES   = 64,
    parameter int DEPTH_BYTES  = 128,
    parameter int WINDOW_BYTES = 15,
    localparam int WV_W        = $clog2(WINDOW_BYTES + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [63:0]               entry,
    input  logic                      redirect_valid,
    input  logic [63:0]               redirect_pc,
    output logic                      req_cyc,
    output logic [63:0]               req_addr,
    input  logic                      req_ack,
    input  logic                      resp_cyc,
    input  logic [8*BEAT_BYTES-1:0]   resp_data,
    output logic                      resp_ack,
    output logic [8*WINDOW_BYTES-1:0] win_bytes,
    output logic [WV_W-1:0]           win_valid,
    output logic [63:0]               win_pc,
    input  logic [WV_W-1:0]           consume,
    output logic                      err_overconsume,
    output logic                      idle
);
    localparam int PTR_W  = $clog2(DEPTH_BYTES);
    localparam int CNT_W  = PTR_W + 1;
    localparam int LINE_W = $clog2(LINE_BYTES);
    localparam int NBEATS = LINE_BYTES / BEAT_BYTES;
    localparam int BC_W   = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int SK_W   = $clog2(BEAT_BYTES + 1);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_ACTIVE, S_DRAIN} state_t;

    state_t           state_reg, state_next;
    logic [63:0]      fetch_pc_reg, win_pc_reg, req_addr_reg;
    logic [PTR_W-1:0] head_reg, tail_reg;
    logic [CNT_W-1:0] count_reg;
    logic [BC_W-1:0]  beat_cnt_reg;
    logic             kill_reg;
    logic             err_reg;
    logic [7:0]       mem [DEPTH_BYTES];

    logic             in_burst, beat_in, last_beat, do_write, over;
    logic [LINE_W:0]  line_off, beat_off, skip_full;
    logic [SK_W-1:0]  nskip, nwrite;
    logic [WV_W-1:0]  valid_now, eff_consume;

    // Beat bookkeeping: how many leading bytes of this beat sit below fetch_pc
    // (only non-zero on the first line after reset/redirect) and how many land.
    always_comb begin
        in_burst  = (state_reg == S_WAIT) || (state_reg == S_ACTIVE);
        beat_in   = resp_cyc && (in_burst || (state_reg == S_DRAIN));
        last_beat = beat_in && (beat_cnt_reg == BC_W'(NBEATS - 1));
        do_write  = resp_cyc && in_burst && !redirect_valid;
        line_off  = {1'b0, fetch_pc_reg[LINE_W-1:0]};
        beat_off  = (LINE_W+1)'(beat_cnt_reg) * (LINE_W+1)'(BEAT_BYTES);
        if (line_off <= beat_off)
            skip_full = '0;
        else if (line_off >= beat_off + (LINE_W+1)'(BEAT_BYTES))
            skip_full = (LINE_W+1)'(BEAT_BYTES);
        else
            skip_full = line_off - beat_off;
        nskip  = SK_W'(skip_full);
        nwrite = do_write ? (SK_W'(BEAT_BYTES) - nskip) : '0;
    end

    // Window occupancy and consume clamping; asking for more than is shown is flagged.
    always_comb begin
        valid_now   = (count_reg >= CNT_W'(WINDOW_BYTES)) ? WV_W'(WINDOW_BYTES)
                                                          : WV_W'(count_reg);
        over        = consume > valid_now;
        eff_consume = over ? valid_now : consume;
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_reg <= S_IDLE;
        else
            state_reg <= state_next;
    end

    // FSM next state and request strobe; redirect only alters where a burst ends up.
    always_comb begin
        state_next = state_reg;
        req_cyc    = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (!redirect_valid && (count_reg <= CNT_W'(DEPTH_BYTES - LINE_BYTES)))
                    state_next = S_REQ;
            end
            S_REQ: begin
                req_cyc = 1'b1;
                if (req_ack)
                    state_next = (kill_reg || redirect_valid) ? S_DRAIN : S_WAIT;
            end
            S_WAIT, S_ACTIVE: begin
                if (last_beat)
                    state_next = S_IDLE;
                else if (redirect_valid)
                    state_next = S_DRAIN;
                else if (resp_cyc)
                    state_next = S_ACTIVE;
            end
            S_DRAIN: begin
                if (last_beat)
                    state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Queue pointers, PCs, beat counter and sticky error; redirect overrides the rest.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_reg <= entry;
            win_pc_reg   <= entry;
            req_addr_reg <= '0;
            head_reg     <= '0;
            tail_reg     <= '0;
            count_reg    <= '0;
            beat_cnt_reg <= '0;
            kill_reg     <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            if (redirect_valid) begin
                count_reg    <= '0;
                head_reg     <= tail_reg;
                win_pc_reg   <= redirect_pc;
                fetch_pc_reg <= redirect_pc;
            end else begin
                head_reg   <= head_reg + PTR_W'(eff_consume);
                tail_reg   <= tail_reg + PTR_W'(nwrite);
                count_reg  <= count_reg + CNT_W'(nwrite) - CNT_W'(eff_consume);
                win_pc_reg <= win_pc_reg + 64'(eff_consume);
                if (over)
                    err_reg <= 1'b1;
                if (last_beat && in_burst)
                    fetch_pc_reg <= req_addr_reg + 64'(LINE_BYTES);
            end
            if ((state_reg == S_IDLE) && (state_next == S_REQ))
                req_addr_reg <= {fetch_pc_reg[63:LINE_W], LINE_W'(0)};
            if ((state_reg == S_REQ) && req_ack)
                beat_cnt_reg <= '0;
            else if (beat_in)
                beat_cnt_reg <= beat_cnt_reg + BC_W'(1);
            // A request redirected before its ack must be drained once acked.
            kill_reg <= (state_reg == S_REQ) && !req_ack && (kill_reg || redirect_valid);
        end
    end

    // Byte store: the surviving suffix of a beat is packed contiguously at tail.
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int j = 0; j < BEAT_BYTES; j++) begin
                if (SK_W'(j) >= nskip)
                    mem[tail_reg + PTR_W'(j) - PTR_W'(nskip)] <= resp_data[8*j +: 8];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < WINDOW_BYTES; gi++) begin : g_win
            assign win_bytes[8*gi +: 8] = mem[head_reg + PTR_W'(gi)];
        end
    endgenerate

    assign req_addr        = req_addr_reg;
    assign resp_ack        = resp_cyc;
    assign win_valid       = valid_now;
    assign win_pc          = win_pc_reg;
    assign err_overconsume = err_reg;
    assign idle            = (state_reg == S_IDLE) && !req_cyc;

endmodule
